// File: rtl/clock_pkg.sv
// Shared constants for the clock timekeeping slice: field select codes,
// field limits and field widths.
package clock_pkg;

   // Field select encodings (o_sel)
   localparam logic [1:0] SEL_SS = 2'd0;
   localparam logic [1:0] SEL_MM = 2'd1;
   localparam logic [1:0] SEL_HH = 2'd2;
   localparam logic [1:0] SEL_PM = 2'd3;

   // Field limits
   localparam int unsigned MAX_SS    = 59;
   localparam int unsigned MAX_MM    = 59;
   localparam int unsigned MAX_HH_12 = 12;
   localparam int unsigned MAX_HH_24 = 23;

   // Field widths
   localparam int unsigned HH_W = 5;
   localparam int unsigned MS_W = 6;

endpackage

// File: rtl/clock_time_keeper_tick_prescaler.sv
// tick_prescaler: free-running 0..CLK_HZ-1 counter with enable. The counter is
// held at zero while disabled, so re-enabling gives a full period before the
// next tick. o_tick is high for the single cycle in which the count wraps.
module tick_prescaler #(
   parameter int unsigned CLK_HZ = 12000000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_en,
   output logic o_tick
);

   localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt_q;

   // Count while enabled, wrap at TERM, clear while disabled
   always_ff @(posedge i_clk) begin
      if (i_reset || !i_en) begin
         cnt_q <= '0;
      end else if (cnt_q == TERM) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign o_tick = i_en && (cnt_q == TERM);

endmodule

// File: rtl/clock_time_keeper.sv
// clock_time_keeper: 1 Hz timekeeping (hh:mm:ss, 12-hour with AM/PM) plus a
// button-driven edit mode. Define CLOCK_24H_EN to build a 24-hour clock
// (hours 0..23, o_pm held at 0, pm field not selectable).
module clock_time_keeper
   import clock_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 12000000,
   parameter int unsigned RESET_HH = 12,
   parameter int unsigned RESET_MM = 0
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_wr_pulse,
   input  logic            i_sel_inc_pulse,
   input  logic            i_sel_dec_pulse,
   input  logic            i_val_inc_pulse,
   input  logic            i_val_dec_pulse,
   output logic [HH_W-1:0] o_hh,
   output logic [MS_W-1:0] o_mm,
   output logic [MS_W-1:0] o_ss,
   output logic            o_pm,
   output logic            o_wr,
   output logic [1:0]      o_sel,
   output logic            o_hz,
   output logic            o_update
);

   localparam logic [MS_W-1:0] SS_MAX = MS_W'(MAX_SS);
   localparam logic [MS_W-1:0] MM_MAX = MS_W'(MAX_MM);
`ifdef CLOCK_24H_EN
   localparam logic [HH_W-1:0] HH_MIN = HH_W'(0);
   localparam logic [HH_W-1:0] HH_MAX = HH_W'(MAX_HH_24);
`else
   localparam logic [HH_W-1:0] HH_MIN = HH_W'(1);
   localparam logic [HH_W-1:0] HH_MAX = HH_W'(MAX_HH_12);
`endif

   logic [HH_W-1:0] hh_q, hh_d;
   logic [MS_W-1:0] mm_q, mm_d;
   logic [MS_W-1:0] ss_q, ss_d;
   logic            pm_q, pm_d;
   logic            wr_q, wr_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      sel_next, sel_prev;
   logic            chg_q, chg_d;
   logic            upd_q;
   logic            run_en;
   logic            hz;

   assign run_en = ~wr_q;

   tick_prescaler #(
      .CLK_HZ (CLK_HZ)
   ) u_prescaler (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (run_en),
      .o_tick  (hz)
   );

   // Neighbouring field selections, skipping pm in the 24-hour build
   always_comb begin
`ifdef CLOCK_24H_EN
      sel_next = (sel_q == SEL_HH) ? SEL_SS : sel_q + 2'd1;
      sel_prev = (sel_q == SEL_SS) ? SEL_HH : sel_q - 2'd1;
`else
      sel_next = sel_q + 2'd1;
      sel_prev = sel_q - 2'd1;
`endif
   end

   // Next-state: mode toggle beats select beats value edit; ticks only in run
   always_comb begin
      hh_d  = hh_q;
      mm_d  = mm_q;
      ss_d  = ss_q;
      pm_d  = pm_q;
      wr_d  = wr_q;
      sel_d = sel_q;
      if (i_wr_pulse) begin
         wr_d = ~wr_q;
         if (!wr_q) begin
            sel_d = SEL_SS;
         end
      end else if (wr_q) begin
         if (i_sel_inc_pulse || i_sel_dec_pulse) begin
            // Opposing select pulses cancel; value pulses are dropped either way
            if (i_sel_inc_pulse && !i_sel_dec_pulse) begin
               sel_d = sel_next;
            end else if (i_sel_dec_pulse && !i_sel_inc_pulse) begin
               sel_d = sel_prev;
            end
         end else if (i_val_inc_pulse ^ i_val_dec_pulse) begin
            case (sel_q)
               SEL_SS: begin
                  if (i_val_inc_pulse) ss_d = (ss_q == SS_MAX) ? '0 : ss_q + 1'b1;
                  else                 ss_d = (ss_q == '0) ? SS_MAX : ss_q - 1'b1;
               end
               SEL_MM: begin
                  if (i_val_inc_pulse) mm_d = (mm_q == MM_MAX) ? '0 : mm_q + 1'b1;
                  else                 mm_d = (mm_q == '0) ? MM_MAX : mm_q - 1'b1;
               end
               SEL_HH: begin
                  if (i_val_inc_pulse) hh_d = (hh_q == HH_MAX) ? HH_MIN : hh_q + 1'b1;
                  else                 hh_d = (hh_q == HH_MIN) ? HH_MAX : hh_q - 1'b1;
               end
               default: begin
`ifndef CLOCK_24H_EN
                  pm_d = ~pm_q;
`endif
               end
            endcase
         end
      end else if (hz) begin
         if (ss_q == SS_MAX) begin
            ss_d = '0;
            if (mm_q == MM_MAX) begin
               mm_d = '0;
`ifdef CLOCK_24H_EN
               hh_d = (hh_q == HH_MAX) ? HH_MIN : hh_q + 1'b1;
`else
               // 11 -> 12 is the AM/PM boundary; 12 -> 1 is not
               if (hh_q == HH_W'(11)) begin
                  hh_d = HH_MAX;
                  pm_d = ~pm_q;
               end else if (hh_q == HH_MAX) begin
                  hh_d = HH_MIN;
               end else begin
                  hh_d = hh_q + 1'b1;
               end
`endif
            end else begin
               mm_d = mm_q + 1'b1;
            end
         end else begin
            ss_d = ss_q + 1'b1;
         end
      end
   end

   assign chg_d = ({hh_d, mm_d, ss_d, pm_d, wr_d, sel_d} !=
                   {hh_q, mm_q, ss_q, pm_q, wr_q, sel_q});

   // State registers; o_update trails a change by one extra cycle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         hh_q  <= HH_W'(RESET_HH);
         mm_q  <= MS_W'(RESET_MM);
         ss_q  <= '0;
         pm_q  <= 1'b0;
         wr_q  <= 1'b0;
         sel_q <= SEL_SS;
         chg_q <= 1'b0;
         upd_q <= 1'b1;
      end else begin
         hh_q  <= hh_d;
         mm_q  <= mm_d;
         ss_q  <= ss_d;
         pm_q  <= pm_d;
         wr_q  <= wr_d;
         sel_q <= sel_d;
         chg_q <= chg_d;
         upd_q <= chg_q;
      end
   end

   assign o_hh     = hh_q;
   assign o_mm     = mm_q;
   assign o_ss     = ss_q;
   assign o_pm     = pm_q;
   assign o_wr     = wr_q;
   assign o_sel    = sel_q;
   assign o_hz     = hz;
   assign o_update = upd_q;

endmodule
